p_stage_patdet: RTL

- Output stage of the DSP slice, downstream of the 48-bit ALU.
- Takes the ALU result (P_IN) and carry-out (COUT) and registers them into P/CARRYOUT.
- Runs pattern and inverted-pattern detection on the ALU result, and derives overflow/underflow from current vs. previous detect state.
- Supports auto-reset of the P register on match or on match-loss. Drives P, PCOUT and the status flags to the slice boundary.

---
 rtl/p_stage_patdet.sv | 135 +++++++++++++
 1 files changed

// File: rtl/p_stage_patdet.sv
// Purpose: DSP slice output stage; registers the ALU result and carry, and runs pattern/inverted-pattern detection with overflow/underflow flags and optional auto-reset of P.
// Latency: 1 CLK from P_IN to P with PREG=1; combinational pass-through with PREG=0.
// Backpressure: none; CEP=0 freezes every P/detect/past register. Optional macro PATDET_STICKY_EN adds the sticky overflow/underflow bits.
module p_stage_patdet #(
  parameter int             N                = 48,
  parameter int             PREG             = 1,
  parameter logic [N-1:0]   PATTERN          = '0,
  parameter logic [N-1:0]   MASK             = 48'h3FFF_FFFF_FFFF,
  parameter int             SEL_PATTERN      = 0,
  parameter int             SEL_MASK         = 0,
  parameter int             AUTORESET_PATDET = 0
) (
  input  logic         CLK,
  input  logic         RSTP,
  input  logic         CEP,
  input  logic [N-1:0] P_IN,
  input  logic         COUT,
  input  logic [N-1:0] C_R,
`ifdef PATDET_STICKY_EN
  input  logic         CLR_STICKY,
  output logic         OVF_STICKY,
  output logic         UNF_STICKY,
`endif
  output logic [N-1:0] P,
  output logic [N-1:0] PCOUT,
  output logic         CARRYOUT,
  output logic         PATTERNDETECT,
  output logic         PATTERNBDETECT,
  output logic         OVERFLOW,
  output logic         UNDERFLOW
);

  logic [N-1:0] pat;
  logic [N-1:0] msk;
  logic         match;
  logic         bmatch;

  // Pattern/mask source selection and the two match terms on the raw ALU result
  always_comb begin
    pat    = (SEL_PATTERN != 0) ? C_R : PATTERN;
    msk    = (SEL_MASK != 0) ? C_R : MASK;
    match  = &((~(P_IN ^ pat)) | msk);
    bmatch = &((~(P_IN ^ ~pat)) | msk);
  end

  generate
    if (PREG == 1) begin : g_reg
      logic [N-1:0] p_q;
      logic         carry_q;
      logic         pd_q;
      logic         pbd_q;
      logic         pd_past_q;
      logic         pbd_past_q;
      logic         auto_rst;

      // Auto-reset fires on the registered detect state, only on enabled edges
      always_comb begin
        auto_rst = 1'b0;
        if (AUTORESET_PATDET == 1)
          auto_rst = pd_q;
        else if (AUTORESET_PATDET == 2)
          auto_rst = pd_past_q & ~pd_q;
        auto_rst = auto_rst & CEP;
      end

      // Result/detect registers: reset, then auto-reset, then load; past state tracks detect on every enabled edge
      always_ff @(posedge CLK) begin
        if (!RSTP) begin
          p_q        <= '0;
          carry_q    <= 1'b0;
          pd_q       <= 1'b0;
          pbd_q      <= 1'b0;
          pd_past_q  <= 1'b0;
          pbd_past_q <= 1'b0;
        end else if (CEP) begin
          pd_past_q  <= pd_q;
          pbd_past_q <= pbd_q;
          if (auto_rst) begin
            p_q     <= '0;
            carry_q <= 1'b0;
            pd_q    <= 1'b0;
            pbd_q   <= 1'b0;
          end else begin
            p_q     <= P_IN;
            carry_q <= COUT;
            pd_q    <= match;
            pbd_q   <= bmatch;
          end
        end
      end

      // Flags decode from registered state only; a drop out of either detect band raises one
      always_comb begin
        P              = p_q;
        PCOUT          = p_q;
        CARRYOUT       = carry_q;
        PATTERNDETECT  = pd_q;
        PATTERNBDETECT = pbd_q;
        OVERFLOW       = pd_past_q & ~pd_q & ~pbd_q;
        UNDERFLOW      = pbd_past_q & ~pd_q & ~pbd_q;
      end
    end else begin : g_comb
      // Unregistered stage: no history, so overflow/underflow cannot be formed
      always_comb begin
        P              = P_IN;
        PCOUT          = P_IN;
        CARRYOUT       = COUT;
        PATTERNDETECT  = match;
        PATTERNBDETECT = bmatch;
        OVERFLOW       = 1'b0;
        UNDERFLOW      = 1'b0;
      end
    end
  endgenerate

`ifdef PATDET_STICKY_EN
  // Sticky flags capture any flag pulse regardless of CEP; a set beats a same-cycle clear
  always_ff @(posedge CLK) begin
    if (!RSTP) begin
      OVF_STICKY <= 1'b0;
      UNF_STICKY <= 1'b0;
    end else begin
      if (OVERFLOW)
        OVF_STICKY <= 1'b1;
      else if (CLR_STICKY)
        OVF_STICKY <= 1'b0;
      if (UNDERFLOW)
        UNF_STICKY <= 1'b1;
      else if (CLR_STICKY)
        UNF_STICKY <= 1'b0;
    end
  end
`endif

endmodule
